mag_cmp_seq: RTL

//  Parametrised, chunk-serial magnitude comparator. Successor to the 1-bit G/E/L comparator.

---
 rtl/mag_cmp_seq.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mag_cmp_seq.sv
// Chunk-serial MSB-first magnitude comparator (unsigned or two's-complement), one-hot G/E/L result.
// Latency: N = WIDTH/CHUNK cycles from start to done; fewer when MAG_CMP_SEQ_EARLY_EXIT_EN is defined.
// Backpressure: start is ignored while busy; a start in the done cycle is accepted back-to-back.
module mag_cmp_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             G,
    output logic             E,
    output logic             L
);

    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             mode_q;
    logic [IW-1:0]    idx;
    logic             gt_q;
    logic             lt_q;

    logic [WIDTH-1:0] a_cmp;
    logic [WIDTH-1:0] b_cmp;
    logic [CHUNK-1:0] ca;
    logic [CHUNK-1:0] cb;
    logic             nxt_gt;
    logic             nxt_lt;
    logic             last;
    logic             accept;

    // Select the current chunk of the (sign-adjusted) latched operands and fold it into the running result.
    always_comb begin
        a_cmp = mode_q ? (a_q ^ MSB_MASK) : a_q;
        b_cmp = mode_q ? (b_q ^ MSB_MASK) : b_q;
        ca    = '0;
        cb    = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == IW'(i)) begin
                ca = a_cmp[i*CHUNK +: CHUNK];
                cb = b_cmp[i*CHUNK +: CHUNK];
            end
        end
        // Once a higher chunk has decided the order, lower chunks cannot change it.
        nxt_gt = gt_q | (~gt_q & ~lt_q & (ca > cb));
        nxt_lt = lt_q | (~gt_q & ~lt_q & (ca < cb));
        last   = (idx == '0);
        accept = start && ((state == IDLE) || (state == DONE));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = RUN;
            end
            RUN: begin
                busy = 1'b1;
`ifdef MAG_CMP_SEQ_EARLY_EXIT_EN
                if (last || (ca != cb)) next_state = DONE;
`else
                if (last) next_state = DONE;
`endif
            end
            DONE: begin
                done       = 1'b1;
                next_state = start ? RUN : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Operand capture, chunk walk and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= 1'b0;
            idx    <= '0;
            gt_q   <= 1'b0;
            lt_q   <= 1'b0;
            G      <= 1'b0;
            E      <= 1'b0;
            L      <= 1'b0;
        end else if (accept) begin
            a_q    <= a;
            b_q    <= b;
            mode_q <= signed_mode;
            idx    <= IW'(N - 1);
            gt_q   <= 1'b0;
            lt_q   <= 1'b0;
            G      <= 1'b0;
            E      <= 1'b0;
            L      <= 1'b0;
        end else if (state == RUN) begin
            gt_q <= nxt_gt;
            lt_q <= nxt_lt;
            if (!last) idx <= idx - 1'b1;
            if (next_state == DONE) begin
                G <= nxt_gt;
                L <= nxt_lt;
                E <= ~nxt_gt & ~nxt_lt;
            end
        end
    end

endmodule
